// File: rtl/if_pkg.sv
// Shared fetch-unit types and constants: FSM states, branch codes, field layout.
// No logic of its own, so no latency or backpressure behaviour.
// The control unit imports the BR_* codes from here as well.
package if_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        EXECUTE = 2'd2
    } fetch_state_t;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_EQ   = 2'b01;
    localparam logic [1:0] BR_NE   = 2'b10;

    // Opcode occupies the top OPC_W bits; the offset field sits directly below it.
    localparam int OPC_W = 8;
    localparam int OFF_W = 8;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/branch_target_calc.sv
// Next-PC selection: sequential PC+4, or PC+4 plus a signed word offset when taken.
// Purely combinational, zero latency.
// No handshake; the caller samples next_pc when it advances.
module branch_target_calc
    import if_pkg::*;
#(
    parameter int PCW  = 32,
    parameter int OFFW = 8
) (
    input  logic [PCW-1:0]  pc,
    input  logic [OFFW-1:0] offset,
    input  logic            jump,
    input  logic [1:0]      branch,
    input  logic            zero,
    output logic [PCW-1:0]  next_pc
);

    logic [PCW-1:0] seq_pc;
    logic [PCW-1:0] off_ext;
    logic [PCW-1:0] target_pc;
    logic           taken;

    assign seq_pc    = pc + PCW'(PC_STEP);
    assign off_ext   = {{(PCW-OFFW){offset[OFFW-1]}}, offset};
    assign target_pc = seq_pc + (off_ext << 2);

    // Code 2'b11 is reserved and falls through as not taken.
    assign taken = jump
                 | ((branch == BR_EQ) &  zero)
                 | ((branch == BR_NE) & ~zero);

    assign next_pc = taken ? target_pc : seq_pc;

endmodule

// File: rtl/instruction_fetch_unit.sv
// PC owner and instruction-memory fetcher feeding the decoder with a registered word.
// Two cycles per instruction (FETCH, EXECUTE) plus one per IMEM or DMEM busy cycle.
// IMEM_BUSYWAIT holds the read request; DMEM_BUSYWAIT holds the current instruction.
module instruction_fetch_unit
    import if_pkg::*;
#(
    parameter int I    = 32,
    parameter int PCW  = 32,
    parameter int OFFW = 8
) (
    input  logic           CLK,
    input  logic           RESET,
    output logic           IMEM_READ,
    output logic [PCW-1:0] IMEM_ADDR,
    input  logic [I-1:0]   IMEM_READDATA,
    input  logic           IMEM_BUSYWAIT,
    input  logic           DMEM_BUSYWAIT,
    input  logic           JUMP,
    input  logic [1:0]     BRANCH,
    input  logic           ZERO,
    output logic [I-1:0]   INSTRUCTION,
    output logic           INSTR_VALID,
    output logic [PCW-1:0] PC
);

    fetch_state_t   state_q, state_d;
    logic [PCW-1:0] pc_q, pc_d;
    logic [PCW-1:0] addr_q, addr_d;
    logic           read_q, read_d;
    logic [I-1:0]   instr_q, instr_d;
    logic           valid_q, valid_d;
    logic [PCW-1:0] next_pc;

    branch_target_calc #(
        .PCW  (PCW),
        .OFFW (OFFW)
    ) u_branch_target_calc (
        .pc      (pc_q),
        .offset  (instr_q[I-OPC_W-1 -: OFFW]),
        .jump    (JUMP),
        .branch  (BRANCH),
        .zero    (ZERO),
        .next_pc (next_pc)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            pc_q    <= '0;
            addr_q  <= '0;
            read_q  <= 1'b0;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            read_q  <= read_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        read_d  = read_q;
        instr_d = instr_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                read_d  = 1'b1;
                addr_d  = pc_q;
            end
            FETCH: begin
                if (!IMEM_BUSYWAIT) begin
                    instr_d = IMEM_READDATA;
                    valid_d = 1'b1;
                    read_d  = 1'b0;
                    state_d = EXECUTE;
                end
            end
            EXECUTE: begin
                // INSTRUCTION is left alone here; only the next accept replaces it.
                if (!DMEM_BUSYWAIT) begin
                    pc_d    = next_pc;
                    addr_d  = next_pc;
                    valid_d = 1'b0;
                    read_d  = 1'b1;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign IMEM_READ   = read_q;
    assign IMEM_ADDR   = addr_q;
    assign INSTRUCTION = instr_q;
    assign INSTR_VALID = valid_q;
    assign PC          = pc_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed vectors, corner sequences and random
// stimulus, all checked cycle by cycle against a transaction-level reference model.
module tb_instruction_fetch_unit;

    logic        CLK;
    logic        RESET;
    logic        IMEM_READ;
    logic [31:0] IMEM_ADDR;
    logic [31:0] IMEM_READDATA;
    logic        IMEM_BUSYWAIT;
    logic        DMEM_BUSYWAIT;
    logic        JUMP;
    logic [1:0]  BRANCH;
    logic        ZERO;
    logic [31:0] INSTRUCTION;
    logic        INSTR_VALID;
    logic [31:0] PC;

    instruction_fetch_unit dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .IMEM_READ     (IMEM_READ),
        .IMEM_ADDR     (IMEM_ADDR),
        .IMEM_READDATA (IMEM_READDATA),
        .IMEM_BUSYWAIT (IMEM_BUSYWAIT),
        .DMEM_BUSYWAIT (DMEM_BUSYWAIT),
        .JUMP          (JUMP),
        .BRANCH        (BRANCH),
        .ZERO          (ZERO),
        .INSTRUCTION   (INSTRUCTION),
        .INSTR_VALID   (INSTR_VALID),
        .PC            (PC)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [logic [31:0]];

    // Reference model: what the unit should present after each edge.
    logic [31:0] m_pc, m_addr, m_instr;
    bit          m_read, m_valid;

    typedef struct {
        string       name;
        logic [7:0]  goto_off;
        logic [31:0] pc;
        logic [7:0]  off;
        bit          j;
        logic [1:0]  br;
        bit          z;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [11];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E3779B1) ^ 32'h13572468;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("pc",          PC,                m_pc);
        chk("imem_addr",   IMEM_ADDR,         m_addr);
        chk("imem_read",   32'(IMEM_READ),    32'(m_read));
        chk("instr_valid", 32'(INSTR_VALID),  32'(m_valid));
        chk("instruction", INSTRUCTION,       m_instr);
    endtask

    function automatic void model_step(input bit rst, input bit ib, input bit db,
                                       input bit j, input logic [1:0] br, input bit z);
        logic signed [7:0] o;
        int                oi;
        bit                taken;
        logic [31:0]       nxt;
        if (rst) begin
            m_pc = 0; m_addr = 0; m_instr = 0; m_read = 0; m_valid = 0;
        end else if (!m_read && !m_valid) begin
            m_read = 1; m_addr = m_pc;
        end else if (m_read) begin
            if (!ib) begin
                m_instr = mem_rd(m_addr); m_valid = 1; m_read = 0;
            end
        end else if (!db) begin
            o     = m_instr[23:16];
            oi    = o;
            taken = j || (br == 2'b01 && z) || (br == 2'b10 && !z);
            nxt   = taken ? m_pc + 32'd4 + 32'(oi * 4) : m_pc + 32'd4;
            m_pc = nxt; m_addr = nxt; m_valid = 0; m_read = 1;
        end
    endfunction

    // Called just after a falling edge; applies inputs, crosses one rising edge, checks.
    task automatic tick(input bit rst, input bit ib, input bit db,
                        input bit j, input logic [1:0] br, input bit z);
        RESET = rst; IMEM_BUSYWAIT = ib; DMEM_BUSYWAIT = db;
        JUMP = j; BRANCH = br; ZERO = z;
        IMEM_READDATA = ib ? $urandom() : mem_rd(IMEM_ADDR);
        model_step(rst, ib, db, j, br, z);
        @(negedge CLK);
        compare_all();
    endtask

    task automatic do_reset();
        tick(1, 0, 0, 0, 2'b00, 0);
        tick(0, 0, 0, 0, 2'b00, 0);
    endtask

    task automatic run_vec(input vec_t v);
        mem[32'h0] = {8'h0C, v.goto_off, 16'h0000};
        mem[v.pc]  = {8'h0D, v.off, 16'h1234};
        do_reset();
        tick(0, 0, 0, 0, 2'b00, 0);
        tick(0, 0, 0, 1, 2'b00, 0);
        chk({v.name, "_goto"}, PC, v.pc);
        tick(0, 0, 0, 0, 2'b00, 0);
        tick(0, 0, 0, v.j, v.br, v.z);
        chk(v.name, PC, v.exp);
    endtask

    initial begin
        vecs[0]  = '{"beq_taken",   8'h03, 32'h10,       8'hFE, 0, 2'b01, 1, 32'h0C};
        vecs[1]  = '{"beq_not",     8'h03, 32'h10,       8'hFE, 0, 2'b01, 0, 32'h14};
        vecs[2]  = '{"bne_taken",   8'h03, 32'h10,       8'h02, 0, 2'b10, 0, 32'h1C};
        vecs[3]  = '{"bne_not",     8'h03, 32'h10,       8'h02, 0, 2'b10, 1, 32'h14};
        vecs[4]  = '{"br11_z1",     8'h03, 32'h10,       8'h02, 0, 2'b11, 1, 32'h14};
        vecs[5]  = '{"br11_z0",     8'h03, 32'h10,       8'h02, 0, 2'b11, 0, 32'h14};
        vecs[6]  = '{"jump_wrap",   8'hFE, 32'hFFFFFFFC, 8'h01, 1, 2'b00, 0, 32'h04};
        vecs[7]  = '{"seq_wrap",    8'hFE, 32'hFFFFFFFC, 8'h01, 0, 2'b00, 1, 32'h00};
        vecs[8]  = '{"jump_beq",    8'h03, 32'h10,       8'h02, 1, 2'b01, 0, 32'h1C};
        vecs[9]  = '{"off_min",     8'h7F, 32'h200,      8'h80, 1, 2'b00, 0, 32'h04};
        vecs[10] = '{"off_max",     8'h03, 32'h10,       8'h7F, 1, 2'b00, 0, 32'h210};

        RESET = 1; IMEM_BUSYWAIT = 0; DMEM_BUSYWAIT = 0; JUMP = 0; BRANCH = 0; ZERO = 0;
        IMEM_READDATA = 0;
        m_pc = 0; m_addr = 0; m_instr = 0; m_read = 0; m_valid = 0;
        @(negedge CLK);

        // Reset values and two zero-wait instructions.
        mem[32'h0] = 32'h00010005;
        mem[32'h4] = 32'h02030102;
        tick(1, 0, 0, 0, 2'b00, 0);
        chk("reset_instruction", INSTRUCTION, 32'h0);
        chk("reset_read", 32'(IMEM_READ), 32'h0);
        tick(0, 0, 0, 0, 2'b00, 0);
        tick(0, 0, 0, 0, 2'b00, 0);
        chk("word0", INSTRUCTION, 32'h00010005);
        chk("word0_valid", 32'(INSTR_VALID), 32'h1);
        tick(0, 0, 0, 0, 2'b00, 0);
        chk("pc4", PC, 32'h4);
        tick(0, 0, 0, 0, 2'b00, 0);
        chk("word1", INSTRUCTION, 32'h02030102);
        tick(0, 0, 0, 0, 2'b00, 0);

        // IMEM busy three cycles at PC=8, with control inputs toggling meanwhile.
        for (int k = 0; k < 3; k++) begin
            tick(0, 1, 1, 1, 2'b01, 1);
            chk("busy_addr", IMEM_ADDR, 32'h8);
            chk("busy_valid", 32'(INSTR_VALID), 32'h0);
        end
        tick(0, 0, 0, 0, 2'b00, 0);
        chk("busy_latch", INSTRUCTION, mem_rd(32'h8));

        // DMEM stall of two cycles holds everything.
        tick(0, 0, 1, 0, 2'b00, 0);
        tick(0, 0, 1, 0, 2'b00, 0);
        chk("dmem_hold_pc", PC, 32'h8);
        chk("dmem_hold_valid", 32'(INSTR_VALID), 32'h1);
        tick(0, 0, 0, 0, 2'b00, 0);
        chk("dmem_advance", PC, 32'hC);

        // Reset while a fetch is stalled.
        tick(0, 1, 0, 0, 2'b00, 0);
        tick(1, 1, 0, 0, 2'b00, 0);
        chk("rst_read", 32'(IMEM_READ), 32'h0);
        chk("rst_pc", PC, 32'h0);
        tick(0, 1, 0, 0, 2'b00, 0);
        chk("restart_read", 32'(IMEM_READ), 32'h1);
        chk("restart_addr", IMEM_ADDR, 32'h0);

        // Reset during a DMEM stall.
        tick(0, 0, 0, 0, 2'b00, 0);
        tick(0, 0, 1, 0, 2'b00, 0);
        tick(1, 0, 1, 0, 2'b00, 0);
        chk("rst_exec_valid", 32'(INSTR_VALID), 32'h0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Random traffic; memory contents default to a hash of the address.
        mem.delete();
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            tick(($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) == 0),
                 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
